writeback_stage: RTL and testbench
==================================

WRITEBACK_STAGE -- requirements
Module: writeback_stage

Interface
REQ-001 Parameter LOAD_TIMEOUT, default 15, max cycles waited for load data before abort (range 1..255).
REQ-002 clk  input  1  single clock, all state on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 m_valid  input  1  memory-stage result valid.
REQ-005 m_ready  output  1  writeback accepts result this cycle.
REQ-006 m_reg_write  input  1  result targets register file.
REQ-007 m_is_load  input  1  result is a load; data comes from dmem.
REQ-008 m_dest  input  4  destination register address.
REQ-009 m_result  input  16  ALU result (non-load).
REQ-010 dmem_rvalid  input  1  load data valid pulse.
REQ-011 dmem_rdata  input  16  load data.
REQ-012 write_en  output  1  register-file write strobe.
REQ-013 destAddW  output  4  register-file write address.
REQ-014 write_data  output  16  register-file write data.
REQ-015 load_err  output  1  one-cycle pulse, load timed out.
REQ-016 rd_add1, rd_add2  input  4 each  decode read addresses (bypass compare).
REQ-017 fwd_hit1, fwd_hit2  output  1 each  bypass match; fwd_data1, fwd_data2  output  16 each  bypass data.

Function
REQ-018 Transfer occurs when m_valid && m_ready; m_ready = 1 in IDLE and WRITE, 0 in WAIT_LOAD.
REQ-019 States IDLE, WAIT_LOAD, WRITE; all outputs except m_ready and fwd_* are registered.
REQ-020 Transfer with m_reg_write=1, m_is_load=0: capture m_dest/m_result, next state WRITE; write_en high exactly the cycle after transfer (latency 1).
REQ-021 Transfer with m_reg_write=1, m_is_load=1: capture m_dest, next state WAIT_LOAD, clear timeout counter.
REQ-022 Transfer with m_reg_write=0: consumed, no write, state IDLE (m_is_load ignored).
REQ-023 WAIT_LOAD with dmem_rvalid=1: capture dmem_rdata, next state WRITE; write_en high the following cycle with saved dest.
REQ-024 WAIT_LOAD counter increments each cycle without dmem_rvalid; on reaching LOAD_TIMEOUT: load_err pulses one cycle, no write, next state IDLE.
REQ-025 dmem_rvalid in the timeout cycle: data wins, no load_err.
REQ-026 dmem_rvalid outside WAIT_LOAD is ignored.
REQ-027 WRITE state with new transfer: back-to-back ALU results sustain one write per cycle; WRITE without transfer returns to IDLE, write_en low.
REQ-028 write_en is never asserted for two cycles with the same transfer; destAddW/write_data hold last values when write_en=0.
REQ-029 Writes to address 0 are issued normally (register file owns r0 policy).

Reset
REQ-030 reset asserted: state IDLE, m_ready 1 after release, write_en 0, destAddW 0, write_data 0, load_err 0, counter 0.
REQ-031 Reset during WAIT_LOAD abandons the load: no write, no load_err.

Configuration
REQ-032 Macro WB_BYPASS_EN defined: fwd_hitN = write_en && (destAddW == rd_addN), fwd_dataN = write_data, combinational.
REQ-033 WB_BYPASS_EN undefined: ports remain, fwd_hit1/2 and fwd_data1/2 tied 0, rd_add1/2 unused.

Structure
REQ-034 Shared package cpu_pkg holds DATA_W=16, REG_ADDR_W=4 and state typedef wb_state_t.
REQ-035 Timeout counter is sub-module wb_load_timer (clear, enable, expired output, LOAD_TIMEOUT parameter).

Verification
REQ-036 ALU transfer dest=3 result=16'h1234 -> next cycle write_en=1, destAddW=3, write_data=16'h1234; following cycle write_en=0.
REQ-037 Load dest=5, dmem_rvalid 4 cycles later with 16'hBEEF -> m_ready=0 for those cycles, then write_en=1, destAddW=5, write_data=16'hBEEF.
REQ-038 Load with no dmem_rvalid, LOAD_TIMEOUT=15 -> load_err pulse after 15 wait cycles, no write_en, m_ready returns to 1.
REQ-039 Three consecutive ALU transfers (dest 1,2,3) -> write_en high three consecutive cycles with matching addresses/data.
REQ-040 WB_BYPASS_EN defined, write to dest 7 with rd_add1=7, rd_add2=6 -> fwd_hit1=1 with write_data, fwd_hit2=0; undefined -> both 0.
REQ-041 Reset asserted two cycles into WAIT_LOAD, dmem_rvalid after release -> no write_en, no load_err.

Source files
------------

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared widths and writeback state type
package cpu_pkg;

    localparam int DATA_W     = 16;
    localparam int REG_ADDR_W = 4;
    localparam int TMR_W      = 8;

    typedef enum logic [1:0] {
        WB_IDLE      = 2'd0,
        WB_WAIT_LOAD = 2'd1,
        WB_WRITE     = 2'd2
    } wb_state_t;

endpackage

// File: rtl/wb_load_timer.sv
// rtl/wb_load_timer.sv - wait-cycle counter for outstanding loads
module wb_load_timer
    import cpu_pkg::*;
#(
    parameter int LOAD_TIMEOUT = 15
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam logic [TMR_W-1:0] LAST_CNT = TMR_W'(LOAD_TIMEOUT - 1);

    logic [TMR_W-1:0] count;

    // Count wait cycles; clear restarts the count for a fresh load
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + 1'b1;
        end
    end

    // Expired in the wait cycle whose increment would reach LOAD_TIMEOUT
    assign expired = enable && (count == LAST_CNT);

endmodule

// File: rtl/writeback_stage.sv
// rtl/writeback_stage.sv - writeback stage with load wait/timeout, optional bypass (WB_BYPASS_EN)
module writeback_stage
    import cpu_pkg::*;
#(
    parameter int LOAD_TIMEOUT = 15
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  m_valid,
    output logic                  m_ready,
    input  logic                  m_reg_write,
    input  logic                  m_is_load,
    input  logic [REG_ADDR_W-1:0] m_dest,
    input  logic [DATA_W-1:0]     m_result,
    input  logic                  dmem_rvalid,
    input  logic [DATA_W-1:0]     dmem_rdata,
    output logic                  write_en,
    output logic [REG_ADDR_W-1:0] destAddW,
    output logic [DATA_W-1:0]     write_data,
    output logic                  load_err,
    input  logic [REG_ADDR_W-1:0] rd_add1,
    input  logic [REG_ADDR_W-1:0] rd_add2,
    output logic                  fwd_hit1,
    output logic                  fwd_hit2,
    output logic [DATA_W-1:0]     fwd_data1,
    output logic [DATA_W-1:0]     fwd_data2
);

    wb_state_t             state;
    wb_state_t             state_next;
    logic                  xfer;
    logic                  ld_xfer;
    logic                  cap_alu;
    logic                  cap_ld_data;
    logic                  ld_err_next;
    logic                  timer_en;
    logic                  timer_expired;
    logic [REG_ADDR_W-1:0] load_dest;

    assign m_ready  = (state != WB_WAIT_LOAD);
    assign xfer     = m_valid && m_ready;
    assign ld_xfer  = xfer && m_reg_write && m_is_load;
    // Kept outside the FSM process so the timer's expired path does not loop back
    assign timer_en = (state == WB_WAIT_LOAD) && !dmem_rvalid;

    wb_load_timer #(
        .LOAD_TIMEOUT(LOAD_TIMEOUT)
    ) u_load_timer (
        .clk    (clk),
        .reset  (reset),
        .clear  (ld_xfer),
        .enable (timer_en),
        .expired(timer_expired)
    );

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= WB_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and capture decisions; load data beats a same-cycle timeout
    always_comb begin
        state_next  = state;
        cap_alu     = 1'b0;
        cap_ld_data = 1'b0;
        ld_err_next = 1'b0;
        case (state)
            WB_IDLE, WB_WRITE: begin
                if (xfer && m_reg_write) begin
                    if (m_is_load) begin
                        state_next = WB_WAIT_LOAD;
                    end else begin
                        state_next = WB_WRITE;
                        cap_alu    = 1'b1;
                    end
                end else begin
                    state_next = WB_IDLE;
                end
            end
            WB_WAIT_LOAD: begin
                if (dmem_rvalid) begin
                    state_next  = WB_WRITE;
                    cap_ld_data = 1'b1;
                end else if (timer_expired) begin
                    state_next  = WB_IDLE;
                    ld_err_next = 1'b1;
                end
            end
            default: state_next = WB_IDLE;
        endcase
    end

    // Registered write strobe and error pulse; strobe lasts exactly the WRITE cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            write_en <= 1'b0;
            load_err <= 1'b0;
        end else begin
            write_en <= (state_next == WB_WRITE);
            load_err <= ld_err_next;
        end
    end

    // Write address/data; hold last values between writes
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            destAddW   <= '0;
            write_data <= '0;
        end else if (cap_alu) begin
            destAddW   <= m_dest;
            write_data <= m_result;
        end else if (cap_ld_data) begin
            destAddW   <= load_dest;
            write_data <= dmem_rdata;
        end
    end

    // Destination of the outstanding load, parked until its data arrives
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            load_dest <= '0;
        end else if (ld_xfer) begin
            load_dest <= m_dest;
        end
    end

`ifdef WB_BYPASS_EN
    assign fwd_hit1  = write_en && (destAddW == rd_add1);
    assign fwd_hit2  = write_en && (destAddW == rd_add2);
    assign fwd_data1 = write_data;
    assign fwd_data2 = write_data;
`else
    logic unused_rd_add;
    assign unused_rd_add = ^{rd_add1, rd_add2};
    assign fwd_hit1  = 1'b0;
    assign fwd_hit2  = 1'b0;
    assign fwd_data1 = '0;
    assign fwd_data2 = '0;
`endif

endmodule

// File: tb/tb_writeback_stage.sv
// tb/tb_writeback_stage.sv - directed self-checking bench for writeback_stage
module tb_writeback_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        m_valid;
    logic        m_ready;
    logic        m_reg_write;
    logic        m_is_load;
    logic [3:0]  m_dest;
    logic [15:0] m_result;
    logic        dmem_rvalid;
    logic [15:0] dmem_rdata;
    logic        write_en;
    logic [3:0]  destAddW;
    logic [15:0] write_data;
    logic        load_err;
    logic [3:0]  rd_add1;
    logic [3:0]  rd_add2;
    logic        fwd_hit1;
    logic        fwd_hit2;
    logic [15:0] fwd_data1;
    logic [15:0] fwd_data2;

    int n_checks = 0;
    int n_bad    = 0;

    always #5 clk = ~clk;

    writeback_stage #(.LOAD_TIMEOUT(15)) dut (
        .clk        (clk),
        .reset      (reset),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_reg_write(m_reg_write),
        .m_is_load  (m_is_load),
        .m_dest     (m_dest),
        .m_result   (m_result),
        .dmem_rvalid(dmem_rvalid),
        .dmem_rdata (dmem_rdata),
        .write_en   (write_en),
        .destAddW   (destAddW),
        .write_data (write_data),
        .load_err   (load_err),
        .rd_add1    (rd_add1),
        .rd_add2    (rd_add2),
        .fwd_hit1   (fwd_hit1),
        .fwd_hit2   (fwd_hit2),
        .fwd_data1  (fwd_data1),
        .fwd_data2  (fwd_data2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic rw, input logic ld, input logic [3:0] d, input logic [15:0] r);
        m_valid     = 1'b1;
        m_reg_write = rw;
        m_is_load   = ld;
        m_dest      = d;
        m_result    = r;
    endtask

    task automatic idle_in();
        m_valid     = 1'b0;
        m_reg_write = 1'b0;
        m_is_load   = 1'b0;
    endtask

    logic [3:0]  vec_dest [3] = '{4'd1, 4'd2, 4'd3};
    logic [15:0] vec_res  [3] = '{16'h0101, 16'h0202, 16'h0303};
    int n;

    initial begin
        reset = 1'b1;
        idle_in();
        m_dest = '0; m_result = '0;
        dmem_rvalid = 1'b0; dmem_rdata = '0;
        rd_add1 = '0; rd_add2 = '0;
        tick(); tick();
        check("rst_we", write_en, 0);
        check("rst_dest", destAddW, 0);
        check("rst_data", write_data, 0);
        check("rst_err", load_err, 0);
        reset = 1'b0;
        #1;
        check("rst_ready", m_ready, 1);

        // ALU write dest=3
        send(1, 0, 4'd3, 16'h1234);
        tick();
        idle_in();
        check("alu_we", write_en, 1);
        check("alu_dest", destAddW, 3);
        check("alu_data", write_data, 16'h1234);
        tick();
        check("alu_we_off", write_en, 0);
        check("alu_hold_dest", destAddW, 3);
        check("alu_hold_data", write_data, 16'h1234);

        // dmem_rvalid while idle is ignored
        dmem_rvalid = 1'b1; dmem_rdata = 16'h5555;
        tick();
        dmem_rvalid = 1'b0;
        check("stray_rvalid_we", write_en, 0);
        check("stray_rvalid_data", write_data, 16'h1234);

        // Load dest=5, data 4 cycles later
        send(1, 1, 4'd5, 16'hFFFF);
        tick();
        idle_in();
        for (int i = 0; i < 3; i++) begin
            check("ld_wait_ready", m_ready, 0);
            check("ld_wait_we", write_en, 0);
            tick();
        end
        dmem_rvalid = 1'b1; dmem_rdata = 16'hBEEF;
        check("ld_wait_ready4", m_ready, 0);
        tick();
        dmem_rvalid = 1'b0;
        check("ld_we", write_en, 1);
        check("ld_dest", destAddW, 5);
        check("ld_data", write_data, 16'hBEEF);
        check("ld_ready_back", m_ready, 1);
        tick();
        check("ld_we_off", write_en, 0);

        // Load timeout
        send(1, 1, 4'd9, 16'h0);
        tick();
        idle_in();
        n = 0;
        while (m_ready == 1'b0 && n < 40) begin
            if (load_err !== 1'b0) check("to_early_err", load_err, 0);
            tick();
            n++;
        end
        check("to_wait_cycles", n, 15);
        check("to_err", load_err, 1);
        check("to_we", write_en, 0);
        check("to_ready", m_ready, 1);
        check("to_dest_hold", destAddW, 5);
        tick();
        check("to_err_pulse", load_err, 0);

        // Data in the timeout cycle wins
        send(1, 1, 4'd10, 16'h0);
        tick();
        idle_in();
        for (int i = 0; i < 14; i++) tick();
        check("edge_ready", m_ready, 0);
        dmem_rvalid = 1'b1; dmem_rdata = 16'hCAFE;
        tick();
        dmem_rvalid = 1'b0;
        check("edge_we", write_en, 1);
        check("edge_err", load_err, 0);
        check("edge_dest", destAddW, 10);
        check("edge_data", write_data, 16'hCAFE);
        tick();
        check("edge_err_after", load_err, 0);

        // Back-to-back ALU writes
        for (int i = 0; i < 3; i++) begin
            send(1, 0, vec_dest[i], vec_res[i]);
            tick();
            check("b2b_we", write_en, 1);
            check("b2b_dest", destAddW, {28'd0, vec_dest[i]});
            check("b2b_data", write_data, {16'd0, vec_res[i]});
        end
        idle_in();
        tick();
        check("b2b_we_off", write_en, 0);

        // No-write transfer with is_load set is just consumed
        send(0, 1, 4'd8, 16'h7777);
        tick();
        idle_in();
        check("nowr_we", write_en, 0);
        check("nowr_ready", m_ready, 1);
        check("nowr_data", write_data, 16'h0303);

        // Write to r0 still issued
        send(1, 0, 4'd0, 16'hA5A5);
        tick();
        idle_in();
        check("r0_we", write_en, 1);
        check("r0_dest", destAddW, 0);
        check("r0_data", write_data, 16'hA5A5);
        tick();

        // Bypass
        rd_add1 = 4'd7; rd_add2 = 4'd6;
        send(1, 0, 4'd7, 16'h7007);
        tick();
        idle_in();
        check("byp_we", write_en, 1);
`ifdef WB_BYPASS_EN
        check("byp_hit1", fwd_hit1, 1);
        check("byp_data1", fwd_data1, 16'h7007);
        check("byp_hit2", fwd_hit2, 0);
`else
        check("byp_hit1", fwd_hit1, 0);
        check("byp_data1", fwd_data1, 0);
        check("byp_hit2", fwd_hit2, 0);
        check("byp_data2", fwd_data2, 0);
`endif
        tick();
`ifdef WB_BYPASS_EN
        check("byp_hit1_off", fwd_hit1, 0);
`endif

        // Reset two cycles into WAIT_LOAD
        send(1, 1, 4'd12, 16'h0);
        tick();
        idle_in();
        tick(); tick();
        check("rstld_ready_pre", m_ready, 0);
        reset = 1'b1;
        #1;
        check("rstld_ready", m_ready, 1);
        tick();
        reset = 1'b0;
        dmem_rvalid = 1'b1; dmem_rdata = 16'hDEAD;
        tick();
        dmem_rvalid = 1'b0;
        check("rstld_we", write_en, 0);
        check("rstld_err", load_err, 0);
        check("rstld_data", write_data, 0);
        for (int i = 0; i < 16; i++) begin
            tick();
            if (load_err !== 1'b0 || write_en !== 1'b0) check("rstld_late", {write_en, load_err}, 0);
        end
        check("rstld_err_late", load_err, 0);

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
